// File: rtl/nim_move_sequencer.sv
// nim_move_sequencer
// Shares the single Nim step motor between two players. A granted player's move
// releases the motor stop line, counts step pulses down to zero, dwells with the
// motor held, and then pulses done back to that player. A step-pulse watchdog
// raises a sticky fault if the motor stops advancing.
module nim_move_sequencer #(
    parameter int CNT_W   = 8,
    parameter int DWELL   = 10000,
    parameter int TIMEOUT = 2**20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] steps_p0,
    input  logic [CNT_W-1:0] steps_p1,
    input  logic [1:0]       speed_sel,
    input  logic             step_pulse,
    input  logic             clear_fault,
    output logic             motor_stop,
    output logic             motor_dir,
    output logic [1:0]       motor_speed,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             busy,
    output logic             fault
);

    // Watchdog: wd_reg + 1 is the number of consecutive pulse-less RUN cycles
    // including the current one, so the fault fires on the edge that closes the
    // (TIMEOUT-1)th such cycle and is visible TIMEOUT cycles after the last pulse.
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    // The DONE cycle is itself a stopped cycle, so SETTLE lasts DWELL-1 cycles and
    // the motor is held for exactly DWELL cycles before the done pulse appears.
    localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'((DWELL > 1) ? DWELL - 2 : 0);
    localparam bit SKIP_SETTLE = (DWELL == 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [WD_W-1:0]  wd_reg;
    logic [DW_W-1:0]  dwell_reg;
    logic             owner_reg;        // 0 = player 0, 1 = player 1
    logic             last_served_reg;  // player that completed the previous move
    logic             motor_stop_reg;
    logic             motor_dir_reg;
    logic [1:0]       motor_speed_reg;
    logic [1:0]       grant_reg;
    logic [1:0]       done_reg;
    logic             busy_reg;
    logic             fault_reg;

    logic             win_p1_next;
    logic [CNT_W-1:0] win_steps_next;

    // Round-robin pick: a lone requester wins, a tie goes to the player not served last.
    always_comb begin
        win_p1_next = 1'b0;
        if (req == 2'b10) begin
            win_p1_next = 1'b1;
        end else if (req == 2'b11) begin
            win_p1_next = ~last_served_reg;
        end
        win_steps_next = win_p1_next ? steps_p1 : steps_p0;
    end

    // Move sequencer: grant, step counting with watchdog, settle dwell, done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            remaining_reg   <= '0;
            wd_reg          <= '0;
            dwell_reg       <= '0;
            owner_reg       <= 1'b0;
            last_served_reg <= 1'b1;
            motor_stop_reg  <= 1'b1;
            motor_dir_reg   <= 1'b1;
            motor_speed_reg <= 2'b00;
            grant_reg       <= 2'b00;
            done_reg        <= 2'b00;
            busy_reg        <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            done_reg <= 2'b00;
            // A timeout later in this block overrides the clear on the same edge.
            if (clear_fault) begin
                fault_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!fault_reg && (req != 2'b00)) begin
                        owner_reg       <= win_p1_next;
                        grant_reg       <= win_p1_next ? 2'b10 : 2'b01;
                        motor_dir_reg   <= ~win_p1_next;
                        motor_speed_reg <= speed_sel;
                        remaining_reg   <= win_steps_next;
                        wd_reg          <= '0;
                        busy_reg        <= 1'b1;
                        if (win_steps_next != '0) begin
                            motor_stop_reg <= 1'b0;
                            state_reg      <= ST_RUN;
                        end else begin
                            state_reg      <= ST_DONE;
                        end
                    end
                end

                ST_RUN: begin
                    if (step_pulse) begin
                        wd_reg <= '0;
                        if (remaining_reg == CNT_W'(1)) begin
                            motor_stop_reg <= 1'b1;
                            dwell_reg      <= '0;
                            state_reg      <= SKIP_SETTLE ? ST_DONE : ST_SETTLE;
                        end else begin
                            remaining_reg  <= remaining_reg - CNT_W'(1);
                        end
                    end else if (wd_reg == WD_LAST) begin
                        fault_reg      <= 1'b1;
                        motor_stop_reg <= 1'b1;
                        dwell_reg      <= '0;
                        state_reg      <= SKIP_SETTLE ? ST_DONE : ST_SETTLE;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (dwell_reg == DW_LAST) begin
                        state_reg <= ST_DONE;
                    end else begin
                        dwell_reg <= dwell_reg + DW_W'(1);
                    end
                end

                ST_DONE: begin
                    done_reg        <= owner_reg ? 2'b10 : 2'b01;
                    grant_reg       <= 2'b00;
                    busy_reg        <= 1'b0;
                    last_served_reg <= owner_reg;
                    state_reg       <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign motor_stop  = motor_stop_reg;
    assign motor_dir   = motor_dir_reg;
    assign motor_speed = motor_speed_reg;
    assign grant       = grant_reg;
    assign done        = done_reg;
    assign busy        = busy_reg;
    assign fault       = fault_reg;

endmodule

// File: tb/tb_nim_move_sequencer.sv
// Testbench for nim_move_sequencer (DWELL=4, TIMEOUT=16, CNT_W=8).
// Expected behaviour is derived from the move rules: grant one cycle after a
// request, motor released until the final pulse, done DWELL+1 cycles after it,
// fault TIMEOUT cycles after the last pulse, round-robin on ties.
`timescale 1ns/1ps
module tb_nim_move_sequencer;

    localparam int CNT_W   = 8;
    localparam int DWELL   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [CNT_W-1:0] steps_p0;
    logic [CNT_W-1:0] steps_p1;
    logic [1:0]       speed_sel;
    logic             step_pulse;
    logic             clear_fault;
    logic             motor_stop;
    logic             motor_dir;
    logic [1:0]       motor_speed;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic             busy;
    logic             fault;

    int checks   = 0;
    int failures = 0;
    bit model_last;   // player that most recently completed a move

    nim_move_sequencer #(
        .CNT_W  (CNT_W),
        .DWELL  (DWELL),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .steps_p0   (steps_p0),
        .steps_p1   (steps_p1),
        .speed_sel  (speed_sel),
        .step_pulse (step_pulse),
        .clear_fault(clear_fault),
        .motor_stop (motor_stop),
        .motor_dir  (motor_dir),
        .motor_speed(motor_speed),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        req         = 2'b00;
        step_pulse  = 1'b0;
        clear_fault = 1'b0;
        steps_p0    = '0;
        steps_p1    = '0;
        speed_sel   = 2'b00;
        repeat (2) tick();
        reset      = 1'b1;
        model_last = 1'b1;
        tick();
    endtask

    // One complete move. rq is the request pattern, winner follows the tie rule.
    // With hold=1 the request stays asserted so the next move starts in the done cycle.
    task automatic do_move(input logic [1:0] rq, input int s0, input int s1,
                           input logic [1:0] spd, input int gap_lo, input int gap_hi,
                           input bit hold);
        bit         win;
        int         nsteps;
        int         gap;
        logic [1:0] g;
        logic [6:0] exp7;
        logic [6:0] got7;
        win    = (rq == 2'b11) ? ~model_last : rq[1];
        nsteps = win ? s1 : s0;
        g      = win ? 2'b10 : 2'b01;
        req        = rq;
        steps_p0   = CNT_W'(s0);
        steps_p1   = CNT_W'(s1);
        speed_sel  = spd;
        step_pulse = 1'b0;
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_before grant=%b busy=%b expected grant=00 busy=0", grant, busy);
        end
        tick();
        exp7 = {g, ~win, spd, 1'b1, (nsteps == 0)};
        got7 = {grant, motor_dir, motor_speed, busy, motor_stop};
        checks++;
        if (got7 !== exp7) begin
            failures++;
            $display("FAIL grant_cycle {grant,dir,speed,busy,stop} got=%b expected=%b", got7, exp7);
        end
        // Inputs that must be ignored while busy.
        steps_p0  = CNT_W'(s0 + 1 + $urandom_range(3, 0));
        steps_p1  = CNT_W'(s1 + 1 + $urandom_range(3, 0));
        speed_sel = spd ^ 2'b01;
        if (!hold) req = 2'($urandom);
        if (nsteps == 0) begin
            checks++;
            if (done !== 2'b00) begin
                failures++;
                $display("FAIL zero_step_early_done got=%b expected=00", done);
            end
            tick();
        end else begin
            for (int i = 0; i < nsteps; i++) begin
                gap = $urandom_range(gap_hi, gap_lo);
                for (int j = 0; j <= gap; j++) begin
                    step_pulse = (j == gap);
                    checks++;
                    if ({motor_stop, done, grant, motor_speed} !== {1'b0, 2'b00, g, spd}) begin
                        failures++;
                        $display("FAIL run_cycle step=%0d {stop,done,grant,speed} got=%b expected=%b",
                                 i, {motor_stop, done, grant, motor_speed}, {1'b0, 2'b00, g, spd});
                    end
                    tick();
                end
            end
            step_pulse = 1'b0;
            for (int j = 0; j < DWELL; j++) begin
                step_pulse = 1'($urandom_range(1, 0));
                checks++;
                if ({motor_stop, done, busy} !== {1'b1, 2'b00, 1'b1}) begin
                    failures++;
                    $display("FAIL settle cycle=%0d {stop,done,busy} got=%b expected=1001",
                             j, {motor_stop, done, busy});
                end
                tick();
            end
            step_pulse = 1'b0;
        end
        checks++;
        if ({done, grant, busy, motor_stop} !== {g, 2'b00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL done_pulse {done,grant,busy,stop} got=%b expected=%b",
                     {done, grant, busy, motor_stop}, {g, 2'b00, 1'b0, 1'b1});
        end
        model_last = win;
        $display("move owner=P%0d steps=%0d speed=%0d hold=%0d", win, nsteps, spd, hold);
        if (!hold) begin
            req = 2'b00;
            tick();
            checks++;
            if (done !== 2'b00) begin
                failures++;
                $display("FAIL done_width got=%b expected=00", done);
            end
        end
    endtask

    task automatic test_reset();
        logic [9:0] got;
        reset = 1'b0;
        #1;
        got = {motor_stop, motor_dir, motor_speed, grant, done, busy, fault};
        checks++;
        if (got !== 10'b11_00_00_00_00) begin
            failures++;
            $display("FAIL reset_values got=%b expected=1100000000", got);
        end
        apply_reset();
        got = {motor_stop, motor_dir, motor_speed, grant, done, busy, fault};
        checks++;
        if (got !== 10'b11_00_00_00_00) begin
            failures++;
            $display("FAIL after_reset_idle got=%b expected=1100000000", got);
        end
    endtask

    task automatic test_single_move();
        apply_reset();
        do_move(2'b01, 3, 0, 2'd2, 4, 4, 1'b0);
    endtask

    task automatic test_zero_steps();
        apply_reset();
        do_move(2'b10, 0, 0, 2'd1, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req = 2'b11;
        do_move(2'b11, 2, 1, 2'd3, 0, 3, 1'b1);
        do_move(2'b11, 2, 1, 2'd0, 0, 3, 1'b1);
        do_move(2'b11, 2, 1, 2'd2, 0, 3, 1'b1);
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_timeout_fault();
        apply_reset();
        req       = 2'b01;
        steps_p0  = 8'd5;
        speed_sel = 2'd1;
        tick();
        checks++;
        if ({grant, motor_stop} !== 3'b010) begin
            failures++;
            $display("FAIL fault_grant {grant,stop} got=%b expected=010", {grant, motor_stop});
        end
        for (int p = 0; p < 2; p++) begin
            step_pulse = 1'b0;
            tick();
            tick();
            step_pulse = 1'b1;
            tick();
        end
        step_pulse = 1'b0;
        // clear_fault coincides with the timeout edge; the timeout must win.
        for (int j = 1; j < TIMEOUT; j++) begin
            checks++;
            if ({fault, motor_stop} !== 2'b00) begin
                failures++;
                $display("FAIL fault_early cycle=%0d {fault,stop} got=%b expected=00", j, {fault, motor_stop});
            end
            clear_fault = (j == TIMEOUT - 1);
            tick();
        end
        clear_fault = 1'b0;
        checks++;
        if ({fault, motor_stop, busy} !== 3'b111) begin
            failures++;
            $display("FAIL fault_raise {fault,stop,busy} got=%b expected=111", {fault, motor_stop, busy});
        end
        for (int j = 0; j < DWELL; j++) begin
            checks++;
            if (done !== 2'b00) begin
                failures++;
                $display("FAIL fault_settle cycle=%0d done got=%b expected=00", j, done);
            end
            tick();
        end
        checks++;
        if ({done, fault, grant} !== 5'b01_1_00) begin
            failures++;
            $display("FAIL fault_done {done,fault,grant} got=%b expected=01100", {done, fault, grant});
        end
        steps_p0 = 8'd0;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if ({grant, busy, fault} !== 4'b00_0_1) begin
                failures++;
                $display("FAIL fault_blocks_grant {grant,busy,fault} got=%b expected=0001", {grant, busy, fault});
            end
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        checks++;
        if ({fault, grant} !== 3'b0_00) begin
            failures++;
            $display("FAIL fault_clear {fault,grant} got=%b expected=000", {fault, grant});
        end
        tick();
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL grant_after_clear got=%b expected=01", grant);
        end
        tick();
        checks++;
        if (done !== 2'b01) begin
            failures++;
            $display("FAIL done_after_clear got=%b expected=01", done);
        end
        req = 2'b00;
        model_last = 1'b0;
        $display("move owner=P0 timeout fault then zero-step move after clear");
        tick();
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        req       = 2'b01;
        steps_p0  = 8'd4;
        speed_sel = 2'd2;
        tick();
        req = 2'b00;
        checks++;
        if ({motor_stop, busy} !== 2'b01) begin
            failures++;
            $display("FAIL midrun_start {stop,busy} got=%b expected=01", {motor_stop, busy});
        end
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({motor_stop, grant, busy, done} !== 6'b1_00_0_00) begin
            failures++;
            $display("FAIL async_reset {stop,grant,busy,done} got=%b expected=100000",
                     {motor_stop, grant, busy, done});
        end
        tick();
        tick();
        reset      = 1'b1;
        model_last = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step_pulse = 1'($urandom_range(1, 0));
            checks++;
            if ({done, grant, busy, motor_stop} !== 6'b00_00_0_1) begin
                failures++;
                $display("FAIL post_reset_quiet {done,grant,busy,stop} got=%b expected=000001",
                         {done, grant, busy, motor_stop});
            end
            tick();
        end
        step_pulse = 1'b0;
        $display("move aborted by reset after 1 of 4 pulses");
    endtask

    task automatic test_random();
        logic [1:0] rq;
        apply_reset();
        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(2, 0))
                0:       rq = 2'b01;
                1:       rq = 2'b10;
                default: rq = 2'b11;
            endcase
            do_move(rq, $urandom_range(5, 0), $urandom_range(5, 0), 2'($urandom), 0, 9, 1'b0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        req         = 2'b00;
        steps_p0    = '0;
        steps_p1    = '0;
        speed_sel   = 2'b00;
        step_pulse  = 1'b0;
        clear_fault = 1'b0;
        model_last  = 1'b1;
        #2;
        test_reset();
        test_single_move();
        test_zero_steps();
        test_back_to_back();
        test_timeout_fault();
        test_reset_mid_run();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout bench did not complete within time limit");
        $fatal(1, "simulation time limit");
    end

endmodule
